// File: rtl/turfbus_pkg.sv
// Shared definitions for the TURFbus return-direction transmitter:
// register map, default frame header and the transmit FSM states.
package turfbus_pkg;

  localparam logic [7:0]  HDR_BYTE_DEFAULT = 8'hA5;
  localparam logic [3:0]  ADR_DATA         = 4'h0;
  localparam logic [3:0]  ADR_COMMIT       = 4'h4;
  localparam int unsigned BACKOFF_CYCLES   = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    BACKOFF  = 3'd2,
    HDR      = 3'd3,
    LEN      = 3'd4,
    DATA     = 3'd5,
    CSUM     = 3'd6,
    WAIT_REL = 3'd7
  } tx_state_t;

endpackage

// File: rtl/turfbus_tx_fifo.sv
// First-word-fall-through FIFO of 32-bit words with fill count.
// Pointer/count reset flushes the contents; the storage array itself is not reset.
module turfbus_tx_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [31:0]   wr_data,
  input  logic          pop,
  output logic [31:0]   rd_data,
  output logic [AW:0]   fill,
  output logic          full,
  output logic          empty
);

  logic [31:0]   mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = fill[AW];
  assign empty   = (fill == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/turfbus_tx.sv
// TURFbus return-direction transmitter: buffers WISHBONE words and sends them
// as a framed byte stream (header, length, data, XOR checksum) once granted.
module turfbus_tx
  import turfbus_pkg::*;
#(
  parameter int unsigned FIFO_AW     = 4,
  parameter int unsigned REQ_TIMEOUT = 1024,
  parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic [7:0]  td_o,
  output logic        td_stb_o,
  output logic        sreq_n_o,
  input  logic        treq_n_i,
  output logic        busy_o
);

  localparam int unsigned TW = $clog2(REQ_TIMEOUT + BACKOFF_CYCLES) + 1;

  tx_state_t        state, nxt;
  logic [1:0]       treq_sync;
  logic             gnt;
  logic             commit_q;
  logic [FIFO_AW:0] len;
  logic [FIFO_AW:0] words_left;
  logic [1:0]       byte_idx;
  logic [7:0]       csum;
  logic [7:0]       timeouts;
  logic [TW-1:0]    timer;

  logic [31:0]      fifo_rd;
  logic [FIFO_AW:0] fill;
  logic             full;
  logic             empty;
  logic             fifo_push;
  logic             fifo_pop;

  logic             wb_req;
  logic             ack_d;
  logic             go_commit;
  logic             go_read;
  logic [31:0]      status;
  logic [7:0]       head_byte;
  logic [7:0]       td_nxt;
  logic             stb_nxt;
  logic             emit_data;
  logic             timeout_evt;
  logic             unused_sel;

  assign unused_sel = ^sel_i;
  assign gnt        = ~treq_sync[1];
  assign busy_o     = (state != IDLE) | commit_q;
  assign head_byte  = fifo_rd[{byte_idx, 3'b000} +: 8];
  assign status     = {busy_o, 3'(state), 4'b0000, timeouts, 8'(len), 8'(fill)};

  turfbus_tx_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (fifo_push),
    .wr_data (dat_i),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .fill    (fill),
    .full    (full),
    .empty   (empty)
  );

  // Bus side: full-FIFO pushes and commits outside IDLE are stalled by withholding ack.
  always_comb begin
    wb_req    = cyc_i & stb_i & ~ack_o;
    go_read   = wb_req & ~we_i;
    fifo_push = 1'b0;
    go_commit = 1'b0;
    ack_d     = 1'b0;
    if (wb_req) begin
      if (!we_i) begin
        ack_d = 1'b1;
      end else if (adr_i == ADR_DATA) begin
        fifo_push = ~full;
        ack_d     = ~full;
      end else if (adr_i == ADR_COMMIT) begin
        go_commit = (state == IDLE);
        ack_d     = (state == IDLE);
      end else begin
        ack_d = 1'b1;
      end
    end
  end

  // Outputs are registered from the next state, so td_o/td_stb_o/sreq_n_o
  // describe the state being entered on each edge.
  always_comb begin
    nxt         = state;
    td_nxt      = '0;
    stb_nxt     = 1'b0;
    fifo_pop    = 1'b0;
    emit_data   = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      IDLE: if (commit_q) nxt = REQ;
      REQ: begin
        if (gnt) begin
          nxt     = HDR;
          td_nxt  = HDR_BYTE;
          stb_nxt = 1'b1;
        end else if (timer == TW'(REQ_TIMEOUT - 1)) begin
          nxt         = BACKOFF;
          timeout_evt = 1'b1;
        end
      end
      BACKOFF: if (timer == TW'(BACKOFF_CYCLES - 1)) nxt = REQ;
      HDR: begin
        nxt     = LEN;
        td_nxt  = 8'(len);
        stb_nxt = 1'b1;
      end
      LEN, DATA: begin
        stb_nxt = 1'b1;
        if (words_left != '0) begin
          nxt       = DATA;
          td_nxt    = head_byte;
          emit_data = 1'b1;
          fifo_pop  = (byte_idx == 2'd3);
        end else begin
          nxt    = CSUM;
          td_nxt = csum;
        end
      end
      CSUM:     nxt = WAIT_REL;
      WAIT_REL: if (!gnt) nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      treq_sync  <= 2'b11;
      commit_q   <= 1'b0;
      len        <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      timeouts   <= '0;
      timer      <= '0;
      ack_o      <= 1'b0;
      dat_o      <= '0;
      td_o       <= '0;
      td_stb_o   <= 1'b0;
      sreq_n_o   <= 1'b1;
    end else begin
      state     <= nxt;
      treq_sync <= {treq_sync[0], treq_n_i};
      td_o      <= td_nxt;
      td_stb_o  <= stb_nxt;
      sreq_n_o  <= !(nxt inside {REQ, HDR, LEN, DATA, CSUM});
      ack_o     <= ack_d;
      dat_o     <= (go_read && adr_i == ADR_DATA) ? status : '0;
      // The frame length is sampled one cycle after the commit ack; no push
      // can be acked in that cycle, so the fill is the one seen at commit.
      commit_q  <= go_commit & ~empty;
      timer     <= (nxt != state) ? '0 : timer + TW'(1);
      if (timeout_evt && timeouts != 8'hFF) timeouts <= timeouts + 8'd1;
      if (state == IDLE && commit_q) begin
        len        <= fill;
        words_left <= fill;
        byte_idx   <= '0;
        csum       <= '0;
      end else if (nxt == IDLE && state != IDLE) begin
        len <= '0;
      end
      if (emit_data) begin
        byte_idx <= byte_idx + 2'd1;
        csum     <= csum ^ head_byte;
        if (byte_idx == 2'd3) words_left <= words_left - (FIFO_AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_turfbus_tx.sv
// Randomized self-checking bench for turfbus_tx against a queue-based frame model.
module tb_turfbus_tx;

  localparam logic [7:0]  HDR = 8'hA5;
  localparam int unsigned TMO = 1024;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cyc_i, stb_i, we_i;
  logic [3:0]  adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic [7:0]  td_o;
  logic        td_stb_o;
  logic        sreq_n_o;
  logic        treq_n_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mq[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  cap_q[$];
  int          cap_cyc[$];
  int          exp_timeouts = 0;

  turfbus_tx #(
    .FIFO_AW     (4),
    .REQ_TIMEOUT (TMO),
    .HDR_BYTE    (HDR)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .cyc_i    (cyc_i),
    .stb_i    (stb_i),
    .we_i     (we_i),
    .adr_i    (adr_i),
    .dat_i    (dat_i),
    .sel_i    (sel_i),
    .dat_o    (dat_o),
    .ack_o    (ack_o),
    .td_o     (td_o),
    .td_stb_o (td_stb_o),
    .sreq_n_o (sreq_n_o),
    .treq_n_i (treq_n_i),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (td_stb_o) begin
      cap_q.push_back(td_o);
      cap_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input int budget,
                          output bit acked, output int ack_cyc);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d;
    acked = 1'b0; ack_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ack_o) begin
        acked = 1'b1;
        ack_cyc = cyc;
        break;
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
    bit acked = 1'b0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = a; d = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack_o) begin
        acked = 1'b1;
        d = dat_o;
        break;
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    check_eq("read_ack", 32'(acked), 32'd1);
  endtask

  task automatic push_word(input logic [31:0] d, input int budget, output bit acked, output int ack_cyc);
    wb_write(4'h0, d, budget, acked, ack_cyc);
    if (acked) mq.push_back(d);
  endtask

  task automatic push_rand(input int n);
    bit a; int c;
    for (int i = 0; i < n; i++) begin
      push_word($urandom, 10, a, c);
      check_eq("push_ack", 32'(a), 32'd1);
    end
  endtask

  // Model: a commit turns the first L queued words into the expected frame.
  task automatic do_commit(input int budget, output bit acked, output int ack_cyc);
    int unsigned l;
    logic [7:0]  cs;
    logic [31:0] w;
    wb_write(4'h4, 32'h0, budget, acked, ack_cyc);
    if (acked) begin
      l = mq.size();
      if (l > 0) begin
        exp_q.delete(); cap_q.delete(); cap_cyc.delete();
        exp_q.push_back(HDR);
        exp_q.push_back(8'(l));
        cs = 8'h00;
        for (int unsigned k = 0; k < l; k++) begin
          w = mq.pop_front();
          for (int b = 0; b < 4; b++) begin
            exp_q.push_back(w[8*b +: 8]);
            cs ^= w[8*b +: 8];
          end
        end
        exp_q.push_back(cs);
      end
    end
  endtask

  task automatic commit_ok();
    bit a; int c;
    do_commit(10, a, c);
    check_eq("commit_ack", 32'(a), 32'd1);
  endtask

  task automatic wait_frame_done(input int budget, input bit release_gnt);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cap_q.size() >= exp_q.size() && !td_stb_o) begin
        done = 1'b1;
        break;
      end
    end
    check_eq("frame_done", 32'(done), 32'd1);
    if (release_gnt) begin
      treq_n_i = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (!busy_o) begin
          done = 1'b1;
          break;
        end
      end
      check_eq("idle_after_release", 32'(done), 32'd1);
    end
  endtask

  task automatic check_frame(input string tag);
    int n;
    check_eq({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_byte"}, 32'(cap_q[i]), 32'(exp_q[i]));
    if (cap_q.size() > 0)
      check_eq({tag, "_contig"}, 32'(cap_cyc[cap_cyc.size()-1] - cap_cyc[0] + 1), 32'(cap_q.size()));
  endtask

  task automatic send_frame(input string tag, input int gdelay);
    repeat (gdelay) tick();
    treq_n_i = 1'b0;
    wait_frame_done(300, 1'b1);
    check_frame(tag);
  endtask

  task automatic wait_sreq(input logic lvl, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sreq_n_o == lvl) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("sreq_wait", 32'(seen), 32'd1);
  endtask

  initial begin
    bit a; int c; int n; int rel_cyc;
    logic [31:0] st;

    rst_i = 1'b1; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = '0; dat_i = '0; sel_i = 4'hF;
    treq_n_i = 1'b1;
    repeat (3) tick();
    check_eq("rst_ack", 32'(ack_o), 0);
    check_eq("rst_dat", dat_o, 0);
    check_eq("rst_td", 32'(td_o), 0);
    check_eq("rst_stb", 32'(td_stb_o), 0);
    check_eq("rst_sreq", 32'(sreq_n_o), 1);
    check_eq("rst_busy", 32'(busy_o), 0);
    rst_i = 1'b0;
    tick();

    // Directed frame with grant latency and request timing
    push_word(32'h03020100, 10, a, c);
    push_word(32'h07060504, 10, a, c);
    do_commit(10, a, c);
    check_eq("t1_commit_ack", 32'(a), 1);
    check_eq("t1_sreq_at_ack", 32'(sreq_n_o), 1);
    tick();
    check_eq("t1_sreq_fall", 32'(sreq_n_o), 0);
    check_eq("t1_busy", 32'(busy_o), 1);
    repeat (4) tick();
    treq_n_i = 1'b0;
    tick(); check_eq("t1_lat1", 32'(td_stb_o), 0);
    tick(); check_eq("t1_lat2", 32'(td_stb_o), 0);
    tick(); check_eq("t1_lat3", {td_stb_o, td_o}, {1'b1, HDR});
    wait_frame_done(100, 1'b1);
    check_frame("t1");
    check_eq("t1_csum", 32'(exp_q[exp_q.size()-1]), 32'h0);

    // Random frames
    for (int it = 0; it < 5; it++) begin
      push_rand($urandom_range(1, 16));
      commit_ok();
      send_frame("rnd", $urandom_range(0, 30));
    end

    // Full FIFO: 17th write stalls until the first pop
    push_rand(16);
    wb_read(4'h0, st);
    check_eq("full_fill", 32'(st[7:0]), 16);
    push_word(32'hDEADBEEF, 20, a, c);
    check_eq("full_block", 32'(a), 0);
    commit_ok();
    fork
      begin repeat (2) tick(); treq_n_i = 1'b0; end
      push_word(32'hCAFEF00D, 300, a, c);
    join
    check_eq("full_17_acked", 32'(a), 1);
    wait_frame_done(200, 1'b1);
    check_frame("full");
    if (cap_cyc.size() > 5) check_eq("full_17_timing", 32'(c - cap_cyc[5]), 1);
    else check_eq("full_17_timing_short", 32'(cap_cyc.size()), 6);

    // Request timeout and backoff, then a grant on the second request
    commit_ok();
    wait_sreq(1'b0, 5);
    n = 0;
    for (int i = 0; i < TMO + 50; i++) begin
      tick();
      n++;
      if (sreq_n_o) break;
    end
    exp_timeouts++;
    check_eq("tmo_cycles", 32'(n), TMO);
    wb_read(4'h0, st);
    check_eq("tmo_count", 32'(st[23:16]), 32'(exp_timeouts));
    check_eq("tmo_state", 32'(st[30:28]), 2);
    check_eq("tmo_busy", 32'(st[31]), 1);
    check_eq("tmo_len", 32'(st[15:8]), 1);
    wait_sreq(1'b0, 40);
    send_frame("tmo", 1);

    // Empty commit
    do_commit(10, a, c);
    check_eq("empty_ack", 32'(a), 1);
    repeat (3) tick();
    check_eq("empty_busy", 32'(busy_o), 0);
    check_eq("empty_sreq", 32'(sreq_n_o), 1);

    // Reset during DATA, then a fresh frame
    push_rand(4);
    commit_ok();
    treq_n_i = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cap_q.size() >= 6) break;
    end
    check_eq("rst_in_data", 32'(cap_q.size() >= 6), 1);
    rst_i = 1'b1;
    #1;
    check_eq("mrst_stb", 32'(td_stb_o), 0);
    check_eq("mrst_sreq", 32'(sreq_n_o), 1);
    check_eq("mrst_busy", 32'(busy_o), 0);
    check_eq("mrst_td", 32'(td_o), 0);
    mq.delete();
    exp_timeouts = 0;
    treq_n_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    wb_read(4'h0, st);
    check_eq("mrst_status", st, 0);
    push_rand(3);
    commit_ok();
    send_frame("fresh", $urandom_range(0, 10));

    // Grant released during DATA: frame still completes
    push_rand(3);
    commit_ok();
    treq_n_i = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cap_q.size() >= 5) break;
    end
    treq_n_i = 1'b1;
    wait_frame_done(100, 1'b0);
    check_frame("drop");
    repeat (3) tick();
    check_eq("drop_idle", 32'(busy_o), 0);

    // Grant held after CSUM: FSM parks in WAIT_REL and commits stall
    push_rand(2);
    commit_ok();
    treq_n_i = 1'b0;
    wait_frame_done(100, 1'b0);
    check_frame("hold");
    repeat (4) tick();
    wb_read(4'h0, st);
    check_eq("hold_state", 32'(st[30:28]), 7);
    check_eq("hold_sreq", 32'(sreq_n_o), 1);
    push_rand(1);
    do_commit(10, a, c);
    check_eq("hold_commit_block", 32'(a), 0);
    rel_cyc = 0;
    fork
      begin repeat (5) tick(); treq_n_i = 1'b1; rel_cyc = cyc; end
      do_commit(50, a, c);
    join
    check_eq("hold_commit_ack", 32'(a), 1);
    check_eq("hold_commit_lat", 32'(c - rel_cyc), 4);
    send_frame("after_hold", 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
